// File: rtl/cam_frame_writer.sv
// Packs the OV7670 RGB565 byte stream into pixels, optionally binarises by luma,
// and writes a row-major H_ACTIVE x V_ACTIVE frame into the frame buffer write port.
module cam_frame_writer #(
  parameter int unsigned H_ACTIVE = 320,
  parameter int unsigned V_ACTIVE = 240,
  parameter logic [7:0]  THRESH   = 8'd96,
  parameter bit          BINARIZE = 1'b1
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic        cam_valid,
  input  logic [7:0]  cam_data,
  output logic        frame_we,
  output logic [16:0] frame_addr,
  output logic [11:0] frame_din,
  output logic        frame_done,
  output logic        overflow
);

  localparam int unsigned COL_W = $clog2(H_ACTIVE + 1);
  localparam int unsigned ROW_W = $clog2(V_ACTIVE + 1);
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(H_ACTIVE);
  localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(V_ACTIVE);
  localparam logic [16:0]      LAST_ADDR = 17'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [16:0]      LINE_STEP = 17'(H_ACTIVE);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    VBLANK  = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [16:0]        r_line_base;
  logic               r_phase_lo;
  logic [6:0]         r_hi_bits;   // high byte minus bit 3, which no channel uses
  logic               r_href_d;
  logic               r_vsync_d;
  logic               r_we;
  logic [16:0]        r_addr;
  logic [11:0]        r_din;
  logic               r_done;
  logic               r_overflow;

  logic [3:0]  w_r4;
  logic [3:0]  w_g4;
  logic [3:0]  w_b4;
  logic [7:0]  w_luma;
  logic [11:0] w_din;
  logic [16:0] w_wr_addr;

  assign w_r4      = r_hi_bits[6:3];
  assign w_g4      = {r_hi_bits[2:0], cam_data[7]};
  assign w_b4      = cam_data[4:1];
  assign w_luma    = 8'd5 * {4'd0, w_r4} + 8'd9 * {4'd0, w_g4} + 8'd2 * {4'd0, w_b4};
  assign w_din     = BINARIZE ? ((w_luma >= THRESH) ? 12'hFFF : 12'h000) : {w_r4, w_g4, w_b4};
  assign w_wr_addr = r_line_base + 17'(r_col);

  always_ff @(posedge clk25) begin
    if (rst) begin
      r_state     <= WAIT_VS;
      r_col       <= '0;
      r_row       <= '0;
      r_line_base <= '0;
      r_phase_lo  <= 1'b0;
      r_hi_bits   <= '0;
      r_href_d    <= 1'b0;
      r_vsync_d   <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_vsync_d <= cam_vsync;
      r_href_d  <= cam_href;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      if (cam_vsync && !r_vsync_d) begin
        r_overflow <= 1'b0;
      end
      case (r_state)
        WAIT_VS: begin
          if (cam_vsync) r_state <= VBLANK;
        end
        VBLANK: begin
          r_col       <= '0;
          r_row       <= '0;
          r_line_base <= '0;
          r_phase_lo  <= 1'b0;
          if (!cam_vsync) r_state <= ACTIVE;
        end
        ACTIVE: begin
          if (cam_vsync) begin
            // vsync mid-line abandons any half-received pixel
            r_state     <= VBLANK;
            r_col       <= '0;
            r_row       <= '0;
            r_line_base <= '0;
            r_phase_lo  <= 1'b0;
          end else if (r_href_d && !cam_href) begin
            r_phase_lo <= 1'b0;
            if (r_col != '0) begin
              r_row       <= r_row + 1'b1;
              r_line_base <= r_line_base + LINE_STEP;
              r_col       <= '0;
            end
          end else if (cam_href && cam_valid) begin
            if (!r_phase_lo) begin
              r_hi_bits  <= {cam_data[7:4], cam_data[2:0]};
              r_phase_lo <= 1'b1;
            end else begin
              r_phase_lo <= 1'b0;
              if (r_row == ROW_MAX || r_col == COL_MAX) begin
                r_overflow <= 1'b1;
              end else begin
                r_we   <= 1'b1;
                r_addr <= w_wr_addr;
                r_din  <= w_din;
                r_done <= (w_wr_addr == LAST_ADDR);
                r_col  <= r_col + 1'b1;
              end
            end
          end
        end
        default: r_state <= WAIT_VS;
      endcase
    end
  end

  assign frame_we   = r_we;
  assign frame_addr = r_addr;
  assign frame_din  = r_din;
  assign frame_done = r_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed bench for cam_frame_writer: full-width lines with a reduced line count
// so full, overflowing and truncated frames all fit in a short run.
module tb_cam_frame_writer;

  localparam int H = 320;
  localparam int V = 6;
  localparam logic [16:0] LAST = 17'(H * V - 1);

  logic        clk25 = 1'b0;
  logic        rst;
  logic        cam_vsync;
  logic        cam_href;
  logic        cam_valid;
  logic [7:0]  cam_data;
  logic        frame_we;
  logic [16:0] frame_addr;
  logic [11:0] frame_din;
  logic        frame_done;
  logic        overflow;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [16:0] last_addr = '0;

  cam_frame_writer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .THRESH   (8'd96),
    .BINARIZE (1'b1)
  ) dut (
    .clk25      (clk25),
    .rst        (rst),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_valid  (cam_valid),
    .cam_data   (cam_data),
    .frame_we   (frame_we),
    .frame_addr (frame_addr),
    .frame_din  (frame_din),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #20 clk25 = ~clk25;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pixel as two back-to-back byte strobes; the write shows up one cycle after LO.
  task automatic send_px(input logic [7:0] hi, input logic [7:0] lo, input bit exp_wr,
                         input logic [16:0] exp_a, input logic [11:0] exp_d);
    cam_href  = 1'b1;
    cam_valid = 1'b1;
    cam_data  = hi;
    @(posedge clk25); #1;
    check("we_after_hi", 32'(frame_we), 32'd0);
    cam_data = lo;
    @(posedge clk25); #1;
    cam_valid = 1'b0;
    check("we", 32'(frame_we), 32'(exp_wr));
    if (exp_wr) begin
      check("addr", 32'(frame_addr), 32'(exp_a));
      check("din", 32'(frame_din), 32'(exp_d));
      check("done", 32'(frame_done), 32'(exp_a == LAST));
      last_addr = exp_a;
    end
  endtask

  task automatic end_line();
    cam_href  = 1'b0;
    cam_valid = 1'b0;
    repeat (2) @(posedge clk25);
    #1;
    check("we_idle", 32'(frame_we), 32'd0);
    check("addr_hold", 32'(frame_addr), 32'(last_addr));
  endtask

  // pat 0: all FFFF (white); pat 1: cycles 0000 / 630C (y=96) / 528A (y=80)
  task automatic send_line(input int npix, input int row, input int pat, input bit extra_hi);
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [11:0] d;
    for (int c = 0; c < npix; c++) begin
      if (pat == 0) begin
        hi = 8'hFF; lo = 8'hFF; d = 12'hFFF;
      end else if (c % 3 == 0) begin
        hi = 8'h00; lo = 8'h00; d = 12'h000;
      end else if (c % 3 == 1) begin
        hi = 8'h63; lo = 8'h0C; d = 12'hFFF;
      end else begin
        hi = 8'h52; lo = 8'h8A; d = 12'h000;
      end
      send_px(hi, lo, (c < H) && (row < V), 17'(row * H + c), d);
    end
    if (extra_hi) begin
      cam_href  = 1'b1;
      cam_valid = 1'b1;
      cam_data  = 8'h00;
      @(posedge clk25); #1;
      cam_valid = 1'b0;
      check("we_dangling", 32'(frame_we), 32'd0);
    end
    end_line();
    $display("line row=%0d pixels=%0d pat=%0d extra_hi=%0d", row, npix, pat, extra_hi);
  endtask

  task automatic do_vsync();
    cam_href  = 1'b0;
    cam_vsync = 1'b1;
    cam_valid = 1'b1;
    cam_data  = 8'hFF;
    repeat (4) begin
      @(posedge clk25); #1;
      check("we_vblank", 32'(frame_we), 32'd0);
    end
    cam_vsync = 1'b0;
    cam_valid = 1'b0;
    repeat (2) @(posedge clk25);
    #1;
    $display("vsync pulse done");
  endtask

  initial begin
    rst       = 1'b1;
    cam_vsync = 1'b0;
    cam_href  = 1'b0;
    cam_valid = 1'b0;
    cam_data  = 8'h00;
    repeat (2) @(posedge clk25);
    #1;
    check("rst_we", 32'(frame_we), 32'd0);
    check("rst_addr", 32'(frame_addr), 32'd0);
    check("rst_din", 32'(frame_din), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Data before the first vsync must be ignored
    cam_href = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cam_valid = 1'b1;
      cam_data  = 8'hFF;
      @(posedge clk25); #1;
      check("we_wait_vs", 32'(frame_we), 32'd0);
    end
    cam_href  = 1'b0;
    cam_valid = 1'b0;
    $display("wait_vs idle done");

    // Frame A: complete frame, row 1 carries the threshold patterns
    do_vsync();
    for (int r = 0; r < V; r++) send_line(H, r, (r == 1) ? 1 : 0, 1'b0);
    check("ovf_frame_a", 32'(overflow), 32'd0);

    // Frame B: one over-long line, then excess lines
    do_vsync();
    send_line(H + 10, 0, 0, 1'b0);
    check("ovf_h", 32'(overflow), 32'd1);
    for (int r = 1; r < V + 5; r++) send_line(H, r, 0, 1'b0);
    check("ovf_v", 32'(overflow), 32'd1);
    do_vsync();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Frame C: odd byte count on row 0, then vsync arriving mid-line on row 2
    send_line(H, 0, 0, 1'b1);
    send_line(H, 1, 1, 1'b0);
    for (int c = 0; c < 5; c++) send_px(8'hFF, 8'hFF, 1'b1, 17'(2 * H + c), 12'hFFF);
    cam_href  = 1'b1;
    cam_valid = 1'b1;
    cam_data  = 8'hFF;
    @(posedge clk25); #1;
    check("we_mid_hi", 32'(frame_we), 32'd0);
    cam_vsync = 1'b1;
    @(posedge clk25); #1;
    check("we_mid_vsync", 32'(frame_we), 32'd0);
    cam_valid = 1'b0;
    $display("vsync mid-line issued");
    do_vsync();
    for (int c = 0; c < 4; c++) send_px(8'h63, 8'h0C, 1'b1, 17'(c), 12'hFFF);
    end_line();
    check("ovf_end", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
